// File: rtl/prog_scheduler.sv
// prog_scheduler: run sequencer and round-robin arbiter in front of the single-cycle processor.
// A host is granted, the processor is held in init, then started. The block waits for
// the processor's done flag under a cycle-count watchdog and reports status back to that host.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-low block reset
//   host_req      per-host run request (level, held until host_done)
//   host_grant    one-hot owner of the current run, 0 when idle
//   host_done     one-cycle completion pulse to the granted host
//   host_timeout  qualifies host_done: 1 = watchdog expired, 0 = processor halted
//   cycle_count   run length of the last completed run
//   busy          high in every state except idle
//   prog_reset    active-high init to the processor
//   prog_req      start request to the processor
//   prog_ack      processor done (halt) flag
module prog_scheduler #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned CW          = 16,
    parameter int unsigned TIMEOUT     = 4000,
    parameter int unsigned INIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] host_req,
    output logic [NREQ-1:0] host_grant,
    output logic [NREQ-1:0] host_done,
    output logic            host_timeout,
    output logic [CW-1:0]   cycle_count,
    output logic            busy,
    output logic            prog_reset,
    output logic            prog_req,
    input  logic            prog_ack
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned IW = $clog2(INIT_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StInit, StStart, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            timeout_q, timeout_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   init_q, init_d;
    logic [CW-1:0]   cnt_inc;

    logic            pick_found;
    logic [PW-1:0]   pick_j;
    logic [PW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_onehot;

    assign cnt_inc = cnt_q + 1'b1;

    // First requester at or above the pointer, wrapping at NREQ.
    always_comb begin
        pick_found  = 1'b0;
        pick_j      = '0;
        pick_idx    = '0;
        pick_onehot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pick_j = PW'((32'(ptr_q) + i) % NREQ);
            if (!pick_found && host_req[pick_j]) begin
                pick_found  = 1'b1;
                pick_idx    = pick_j;
                pick_onehot = NREQ'(1) << pick_j;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        grant_d   = grant_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        init_d    = init_q;
        unique case (state_q)
            StIdle: begin
                grant_d = '0;
                if (pick_found) begin
                    grant_d = pick_onehot;
                    idx_d   = pick_idx;
                    init_d  = '0;
                    state_d = StInit;
                end
            end
            StInit: begin
                if (init_q == IW'(INIT_CYCLES - 1)) begin
                    state_d = StStart;
                end else begin
                    init_d = init_q + 1'b1;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                cnt_d = cnt_inc;
                // Ack wins over the watchdog when both land in the same cycle.
                if (prog_ack) begin
                    count_d   = cnt_inc;
                    timeout_d = 1'b0;
                    state_d   = StDone;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    count_d   = CW'(TIMEOUT);
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                grant_d   = '0;
                timeout_d = 1'b0;
                ptr_d     = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            idx_q     <= '0;
            grant_q   <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            count_q   <= '0;
            init_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            count_q   <= count_d;
            init_q    <= init_d;
        end
    end

    // Moore decodes of the registered state.
    assign host_grant   = grant_q;
    assign host_done    = (state_q == StDone) ? grant_q : '0;
    assign host_timeout = timeout_q;
    assign cycle_count  = count_q;
    assign busy         = (state_q != StIdle);
    assign prog_reset   = (state_q == StIdle) || (state_q == StInit);
    assign prog_req     = (state_q == StStart);

endmodule

// File: tb/tb_prog_scheduler.sv
module tb_prog_scheduler;

    localparam int unsigned NREQ        = 4;
    localparam int unsigned CW          = 16;
    localparam int unsigned TIMEOUT     = 20;
    localparam int unsigned INIT_CYCLES = 2;

    logic            clk;
    logic            reset;
    logic [NREQ-1:0] host_req;
    logic [NREQ-1:0] host_grant;
    logic [NREQ-1:0] host_done;
    logic            host_timeout;
    logic [CW-1:0]   cycle_count;
    logic            busy;
    logic            prog_reset;
    logic            prog_req;
    logic            prog_ack;

    typedef struct packed {
        logic [NREQ-1:0] grant;
        logic            tmo;
        logic [CW-1:0]   cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    prog_scheduler #(
        .NREQ        (NREQ),
        .CW          (CW),
        .TIMEOUT     (TIMEOUT),
        .INIT_CYCLES (INIT_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .host_req     (host_req),
        .host_grant   (host_grant),
        .host_done    (host_done),
        .host_timeout (host_timeout),
        .cycle_count  (cycle_count),
        .busy         (busy),
        .prog_reset   (prog_reset),
        .prog_req     (prog_req),
        .prog_ack     (prog_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL global_watchdog: simulation did not finish, got time %0t", $time);
        $fatal(1);
    end

    // Steps to the START cycle (prog_req high), bounded.
    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (prog_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Steps until host_done is seen, bounded; reports cycles waited.
    task automatic wait_done(input int limit, output bit ok, output int waited);
        ok     = 1'b0;
        waited = 0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            waited++;
            if (host_done !== '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        host_req = '0;
        prog_ack = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (host_grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant: got %b expected 0000", host_grant); end
        n_cmp++; if (host_done !== 4'b0000) begin n_fail++; $display("FAIL rst_done: got %b expected 0000", host_done); end
        n_cmp++; if (host_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b expected 0", host_timeout); end
        n_cmp++; if (cycle_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", cycle_count); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if (prog_reset !== 1'b1) begin n_fail++; $display("FAIL rst_prog_reset: got %b expected 1", prog_reset); end
        n_cmp++; if (prog_req !== 1'b0) begin n_fail++; $display("FAIL rst_prog_req: got %b expected 0", prog_req); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int   t0;
        exp_t e;
        t0       = cyc;
        host_req = 4'b0001;
        @(negedge clk);
        n_cmp++; if (host_grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected 0001", host_grant); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
        n_cmp++; if (prog_reset !== 1'b1) begin n_fail++; $display("FAIL single_init1: got %b expected 1", prog_reset); end
        @(negedge clk);
        n_cmp++; if ({prog_reset, prog_req} !== 2'b10) begin n_fail++; $display("FAIL single_init2: got rst/req %b expected 10", {prog_reset, prog_req}); end
        @(negedge clk);
        n_cmp++; if ({prog_reset, prog_req} !== 2'b01) begin n_fail++; $display("FAIL single_start: got rst/req %b expected 01", {prog_reset, prog_req}); end
        sb.push_back('{grant: 4'b0001, tmo: 1'b0, cnt: 16'd5});
        repeat (5) @(negedge clk);
        prog_ack = 1'b1;
        @(negedge clk);
        prog_ack = 1'b0;
        n_cmp++; if (cyc - t0 != INIT_CYCLES + 2 + 5) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", cyc - t0, INIT_CYCLES + 7); end
        e = sb.pop_front();
        n_cmp++; if (host_done !== e.grant) begin n_fail++; $display("FAIL single_done: got %b expected %b", host_done, e.grant); end
        n_cmp++; if (host_timeout !== e.tmo) begin n_fail++; $display("FAIL single_tmo: got %b expected %b", host_timeout, e.tmo); end
        n_cmp++; if (cycle_count !== e.cnt) begin n_fail++; $display("FAIL single_count: got %0d expected %0d", cycle_count, e.cnt); end
        host_req = '0;
        @(negedge clk);
        n_cmp++; if (host_done !== 4'b0000) begin n_fail++; $display("FAIL single_done_pulse: got %b expected 0000", host_done); end
        n_cmp++; if ({host_grant, busy, prog_reset} !== 6'b000001) begin n_fail++; $display("FAIL single_idle: got grant/busy/rst %b expected 000001", {host_grant, busy, prog_reset}); end
        n_cmp++; if (cycle_count !== 16'd5) begin n_fail++; $display("FAIL single_count_hold: got %0d expected 5", cycle_count); end
    endtask

    task automatic test_round_robin;
        bit              ok;
        exp_t            e;
        logic [NREQ-1:0] eg;
        // Pointer back to 0 so the rotation starts at host 0.
        reset = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        host_req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            eg = 4'b0001 << (r % 4);
            wait_start(ok);
            if (!ok) begin n_cmp++; n_fail++; $display("FAIL rr_start_wait: got no prog_req expected one in run %0d", r); break; end
            n_cmp++; if (host_grant !== eg) begin n_fail++; $display("FAIL rr_grant: got %b expected %b in run %0d", host_grant, eg, r); end
            n_cmp++; if ($countones(host_grant) != 1) begin n_fail++; $display("FAIL rr_onehot: got %b expected one bit", host_grant); end
            sb.push_back('{grant: eg, tmo: 1'b0, cnt: 16'd3});
            repeat (3) @(negedge clk);
            prog_ack = 1'b1;
            @(negedge clk);
            prog_ack = 1'b0;
            e = sb.pop_front();
            n_cmp++; if (host_done !== e.grant) begin n_fail++; $display("FAIL rr_done: got %b expected %b", host_done, e.grant); end
            n_cmp++; if (cycle_count !== e.cnt) begin n_fail++; $display("FAIL rr_count: got %0d expected %0d", cycle_count, e.cnt); end
            if (r == 4) host_req = '0;
            @(negedge clk);
            n_cmp++; if ({host_grant, busy} !== 5'b00000) begin n_fail++; $display("FAIL rr_gap: got grant/busy %b expected 00000", {host_grant, busy}); end
        end
    endtask

    task automatic test_timeout;
        bit   ok;
        int   waited;
        exp_t e;
        // Pointer is at 1 after the rotation ended on host 0.
        host_req = 4'b0010;
        wait_start(ok);
        if (!ok) begin n_cmp++; n_fail++; $display("FAIL to_start_wait: got no prog_req expected one"); end
        sb.push_back('{grant: 4'b0010, tmo: 1'b1, cnt: 16'(TIMEOUT)});
        wait_done(60, ok, waited);
        if (!ok) begin
            n_cmp++; n_fail++; $display("FAIL to_done_wait: got no host_done expected one within 60 cycles");
        end else begin
            n_cmp++; if (waited != TIMEOUT + 1) begin n_fail++; $display("FAIL to_latency: got %0d expected %0d", waited, TIMEOUT + 1); end
            e = sb.pop_front();
            n_cmp++; if (host_done !== e.grant) begin n_fail++; $display("FAIL to_done: got %b expected %b", host_done, e.grant); end
            n_cmp++; if (host_timeout !== e.tmo) begin n_fail++; $display("FAIL to_tmo: got %b expected %b", host_timeout, e.tmo); end
            n_cmp++; if (cycle_count !== e.cnt) begin n_fail++; $display("FAIL to_count: got %0d expected %0d", cycle_count, e.cnt); end
        end
        host_req = '0;
        @(negedge clk);
        // Ack landing on the watchdog cycle must win.
        host_req = 4'b0100;
        wait_start(ok);
        if (!ok) begin n_cmp++; n_fail++; $display("FAIL race_start_wait: got no prog_req expected one"); end
        sb.push_back('{grant: 4'b0100, tmo: 1'b0, cnt: 16'(TIMEOUT)});
        repeat (TIMEOUT) @(negedge clk);
        prog_ack = 1'b1;
        @(negedge clk);
        prog_ack = 1'b0;
        e = sb.pop_front();
        n_cmp++; if (host_done !== e.grant) begin n_fail++; $display("FAIL race_done: got %b expected %b", host_done, e.grant); end
        n_cmp++; if (host_timeout !== e.tmo) begin n_fail++; $display("FAIL race_tmo: got %b expected %b", host_timeout, e.tmo); end
        n_cmp++; if (cycle_count !== e.cnt) begin n_fail++; $display("FAIL race_count: got %0d expected %0d", cycle_count, e.cnt); end
        host_req = '0;
        @(negedge clk);
    endtask

    task automatic test_stale_ack;
        bit   ok;
        exp_t e;
        prog_ack = 1'b1;
        host_req = 4'b1000;
        ok       = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n_cmp++; if (host_done !== 4'b0000) begin n_fail++; $display("FAIL stale_early_done: got %b expected 0000", host_done); end
            if (prog_req === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin n_cmp++; n_fail++; $display("FAIL stale_start_wait: got no prog_req expected one"); end
        sb.push_back('{grant: 4'b1000, tmo: 1'b0, cnt: 16'd1});
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        n_cmp++; if (host_done !== e.grant) begin n_fail++; $display("FAIL stale_done: got %b expected %b", host_done, e.grant); end
        n_cmp++; if (cycle_count !== e.cnt) begin n_fail++; $display("FAIL stale_count: got %0d expected %0d", cycle_count, e.cnt); end
        n_cmp++; if (host_timeout !== e.tmo) begin n_fail++; $display("FAIL stale_tmo: got %b expected %b", host_timeout, e.tmo); end
        prog_ack = 1'b0;
        host_req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        bit   ok;
        exp_t e;
        // Host 0 completes, moving the pointer to 1.
        host_req = 4'b0001;
        wait_start(ok);
        if (!ok) begin n_cmp++; n_fail++; $display("FAIL mid_start_wait0: got no prog_req expected one"); end
        sb.push_back('{grant: 4'b0001, tmo: 1'b0, cnt: 16'd2});
        repeat (2) @(negedge clk);
        prog_ack = 1'b1;
        @(negedge clk);
        prog_ack = 1'b0;
        e = sb.pop_front();
        n_cmp++; if (host_done !== e.grant) begin n_fail++; $display("FAIL mid_pre_done: got %b expected %b", host_done, e.grant); end
        host_req = 4'b0101;
        wait_start(ok);
        if (!ok) begin n_cmp++; n_fail++; $display("FAIL mid_start_wait1: got no prog_req expected one"); end
        n_cmp++; if (host_grant !== 4'b0100) begin n_fail++; $display("FAIL mid_rot_grant: got %b expected 0100", host_grant); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if ({host_grant, host_done} !== 8'h00) begin n_fail++; $display("FAIL mid_rst_grant_done: got %b expected 00000000", {host_grant, host_done}); end
        n_cmp++; if ({host_timeout, busy, prog_reset, prog_req} !== 4'b0010) begin n_fail++; $display("FAIL mid_rst_ctl: got tmo/busy/rst/req %b expected 0010", {host_timeout, busy, prog_reset, prog_req}); end
        n_cmp++; if (cycle_count !== 16'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d expected 0", cycle_count); end
        reset = 1'b1;
        @(negedge clk);
        // Pointer is back at 0, so host 0 beats host 2.
        n_cmp++; if (host_grant !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_grant: got %b expected 0001", host_grant); end
        n_cmp++; if (host_done !== 4'b0000) begin n_fail++; $display("FAIL mid_no_done: got %b expected 0000", host_done); end
        wait_start(ok);
        if (!ok) begin n_cmp++; n_fail++; $display("FAIL mid_start_wait2: got no prog_req expected one"); end
        sb.push_back('{grant: 4'b0001, tmo: 1'b0, cnt: 16'd4});
        repeat (4) @(negedge clk);
        prog_ack = 1'b1;
        @(negedge clk);
        prog_ack = 1'b0;
        host_req = '0;
        e = sb.pop_front();
        n_cmp++; if (host_done !== e.grant) begin n_fail++; $display("FAIL mid_post_done: got %b expected %b", host_done, e.grant); end
        n_cmp++; if (cycle_count !== e.cnt) begin n_fail++; $display("FAIL mid_post_count: got %0d expected %0d", cycle_count, e.cnt); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_stale_ack();
        test_reset_mid_run();
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d entries expected 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
